arbiter_8x3_rr: RTL and testbench

ARBITER_8X3_RR -- requirements
Module: arbiter_8x3_rr

---
 rtl/arbiter_8x3_rr.sv | 143 ++++++++++++++
 tb/tb_arbiter_8x3_rr.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/arbiter_8x3_rr.sv
// Eight-requester round-robin arbiter with one-hot and binary grant outputs.
// Optional forced release after MAX_HOLD grant cycles: define ARB_TIMEOUT_EN.
module arbiter_8x3_rr #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [2:0] ptr;
    logic [2:0] ptr_nx;
    logic [7:0] hold;
    logic [7:0] hold_nx;
    logic [7:0] gnt_nx;
    logic [2:0] idx_nx;
    logic       valid_nx;

    logic [2:0] pick;
    logic       found;
    logic       owner_req;
    logic       hold_hit;
    logic       force_rel;

    assign owner_req = req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    // Owner has used its full slot once the counter reaches the limit.
    assign hold_hit = (hold >= HOLD_LIM);
`else
    logic unused_cfg;

    assign hold_hit   = 1'b0;
    assign unused_cfg = ^8'(MAX_HOLD);
`endif

    assign force_rel = (state == GRANT) && owner_req && hold_hit;

    // First requester found scanning upward from ptr, wrapping at 7.
    always_comb begin
        pick  = 3'd0;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr + 3'(i)]) begin
                pick  = ptr + 3'(i);
                found = 1'b1;
            end
        end
    end

    // Next-state and next-output decision for the grant FSM.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        hold_nx  = hold;
        gnt_nx   = gnt;
        idx_nx   = gnt_idx;
        valid_nx = gnt_valid;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nx = GRANT;
                    gnt_nx   = 8'(1) << pick;
                    idx_nx   = pick;
                    valid_nx = 1'b1;
                    hold_nx  = 8'd1;
                end
            end
            GRANT: begin
                if (!owner_req || force_rel) begin
                    state_nx = IDLE;
                    gnt_nx   = 8'd0;
                    valid_nx = 1'b0;
                    ptr_nx   = gnt_idx + 3'd1;
                    hold_nx  = 8'd0;
                end else if (hold != 8'hff) begin
                    hold_nx = hold + 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, pointer, counter and registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            hold      <= 8'd0;
            gnt       <= 8'd0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            hold      <= hold_nx;
            gnt       <= gnt_nx;
            gnt_idx   <= idx_nx;
            gnt_valid <= valid_nx;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic timeout_q;

    // One-cycle pulse following a forced release.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_rel;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Structural invariants of the grant outputs.
    a_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt));
    a_valid: assert property (@(posedge clk) disable iff (rst)
        gnt_valid == (gnt != 8'd0));
    a_decode: assert property (@(posedge clk) disable iff (rst)
        gnt_valid |-> (gnt == (8'(1) << gnt_idx)));

endmodule

// File: tb/tb_arbiter_8x3_rr.sv
// Scoreboard bench for arbiter_8x3_rr against a behavioural arbitration model.
// Randomised and directed request patterns; ARB_TIMEOUT_EN selects the model mode.
module tb_arbiter_8x3_rr;

    localparam int MAXH = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       v;
        logic       t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   done  = 1'b0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    int m_last  = 0;

    arbiter_8x3_rr #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_step(input bit r, input logic [7:0] rq);
        exp_t e;
        bit   t;
        t = 1'b0;
        if (r) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
            m_last  = 0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < 8; i++) begin
                int c;
                c = (m_ptr + i) % 8;
                if (m_owner < 0 && rq[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_hold  = 1;
                end
            end
        end else if (!rq[m_owner]) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
        end else if (TO_EN && m_hold >= MAXH) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
            t       = 1'b1;
        end else if (m_hold < 255) begin
            m_hold++;
        end
        e.gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        e.idx = 3'(m_last);
        e.v   = (m_owner >= 0);
        e.t   = t;
        return e;
    endfunction

    task automatic apply(input bit r, input logic [7:0] rq);
        rst = r;
        req = rq;
        q.push_back(model_step(r, rq));
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                tests++;
                if (gnt !== e.gnt || gnt_idx !== e.idx ||
                    gnt_valid !== e.v || timeout !== e.t) begin
                    fails++;
                    $display("FAIL grant cyc=%0d got gnt=%h idx=%0d v=%b t=%b want gnt=%h idx=%0d v=%b t=%b",
                             cyc, gnt, gnt_idx, gnt_valid, timeout,
                             e.gnt, e.idx, e.v, e.t);
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        apply(1'b1, 8'h00);
        apply(1'b1, 8'hff);
        apply(1'b0, 8'h00);
        apply(1'b0, 8'h00);

        // Two requesters, owner 0 drops, 7 follows.
        repeat (3) apply(1'b0, 8'h81);
        repeat (4) apply(1'b0, 8'h80);
        apply(1'b0, 8'h00);

        // All requesting; each owner drops after two grant cycles.
        apply(1'b1, 8'h00);
        for (int i = 0; i < 40; i++) begin
            r = 8'hff;
            if (m_owner >= 0 && m_hold >= 2) r[m_owner] = 1'b0;
            apply(1'b0, r);
        end

        // Other requests ignored while 3 owns.
        apply(1'b1, 8'h00);
        repeat (2) apply(1'b0, 8'h08);
        repeat (2) apply(1'b0, 8'h28);
        repeat (2) apply(1'b0, 8'h08);
        apply(1'b0, 8'h00);

        // Long hold on two requesters.
        apply(1'b1, 8'h00);
        repeat (14) apply(1'b0, 8'h06);
        apply(1'b0, 8'h00);

        // Reset during grant of 6, then all request.
        apply(1'b1, 8'h00);
        repeat (3) apply(1'b0, 8'h40);
        apply(1'b1, 8'h40);
        repeat (5) apply(1'b0, 8'hff);

        // Sole requester re-granted after release.
        apply(1'b0, 8'h00);
        repeat (2) apply(1'b0, 8'h10);
        apply(1'b0, 8'h00);
        repeat (3) apply(1'b0, 8'h10);

        // Random traffic; owners mostly keep their request.
        for (int i = 0; i < 3000; i++) begin
            r = 8'($urandom);
            if (m_owner >= 0) r[m_owner] = ($urandom_range(0, 9) < 8);
            apply($urandom_range(0, 199) == 0, r);
        end

        apply(1'b0, 8'h00);
        done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog got done=%b want done=1", done);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
